// File: rtl/messbauer_sweep_generator.sv
// Mossbauer velocity-sweep timing generator: start pulse, per-slot channel pulses,
// sweep counting with optional stop limit. All outputs lag the internal FSM by one register stage.
module messbauer_sweep_generator #(
  parameter int unsigned CHANNEL_NUMBER      = 4096,
  parameter int unsigned CHANNEL_PERIOD      = 100,
  parameter int unsigned START_DURATION      = 10,
  parameter int unsigned CHANNEL_DURATION    = 1,
  parameter int unsigned CHANNEL_TYPE        = 2,
  parameter int unsigned SWEEPS_LIMIT        = 0,
  parameter int unsigned SWEEP_COUNTER_WIDTH = 16
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                enable,
  output logic                                start,
  output logic                                channel,
  output logic [$clog2(CHANNEL_NUMBER)-1:0]   channel_index,
  output logic [SWEEP_COUNTER_WIDTH-1:0]      sweep_count,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned IDX_W   = $clog2(CHANNEL_NUMBER);
  localparam int unsigned CYC_W   = $clog2(CHANNEL_PERIOD);
  localparam int unsigned START_W = (START_DURATION > 1) ? $clog2(START_DURATION) : 1;
  localparam int unsigned CNT_W   = SWEEP_COUNTER_WIDTH;

  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(CHANNEL_PERIOD - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(CHANNEL_NUMBER - 1);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_DURATION - 1);
  localparam logic [CNT_W-1:0]   LIMIT_VAL  = CNT_W'(SWEEPS_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SLOTS = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Parameter legality is enforced at elaboration
  if (CHANNEL_TYPE != 1 && CHANNEL_TYPE != 2) begin : g_bad_type
    $error("CHANNEL_TYPE must be 1 or 2");
  end
  if (CHANNEL_NUMBER < 2 || CHANNEL_PERIOD < 2 || START_DURATION < 1) begin : g_bad_size
    $error("CHANNEL_NUMBER/CHANNEL_PERIOD must be >= 2, START_DURATION >= 1");
  end
  if (CHANNEL_DURATION < 1 || CHANNEL_DURATION >= CHANNEL_PERIOD) begin : g_bad_dur
    $error("CHANNEL_DURATION must be in 1..CHANNEL_PERIOD-1");
  end

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [START_W-1:0] r_start_cnt;
  logic [CYC_W-1:0]   r_cyc;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_sweep;

  logic               w_start_last;
  logic               w_slot_last;
  logic               w_sweep_last;
  logic [CNT_W-1:0]   w_sweep_nxt;
  logic               w_limit_hit;
  logic               w_chan_win;

  // Channel window position within a slot
  if (CHANNEL_TYPE == 1) begin : g_chan_before
    localparam logic [CYC_W-1:0] CH_END = CYC_W'(CHANNEL_DURATION);
    assign w_chan_win = (r_cyc < CH_END);
  end else begin : g_chan_after
    localparam logic [CYC_W-1:0] CH_BEG = CYC_W'(CHANNEL_PERIOD - CHANNEL_DURATION);
    assign w_chan_win = (r_cyc >= CH_BEG);
  end

  assign w_start_last = (r_start_cnt == START_LAST);
  assign w_slot_last  = (r_cyc == CYC_LAST);
  assign w_sweep_last = w_slot_last && (r_idx == IDX_LAST);
  assign w_sweep_nxt  = r_sweep + CNT_W'(1);
  assign w_limit_hit  = (SWEEPS_LIMIT != 0) && (w_sweep_nxt == LIMIT_VAL);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_START;
      S_START: if (w_start_last) w_state_nxt = S_SLOTS;
      S_SLOTS: begin
        if (w_sweep_last) begin
          if (w_limit_hit)  w_state_nxt = S_DONE;
          else if (enable)  w_state_nxt = S_START;
          else              w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  if (!enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_start_cnt   <= '0;
      r_cyc         <= '0;
      r_idx         <= '0;
      r_sweep       <= '0;
      start         <= 1'b0;
      channel       <= 1'b0;
      channel_index <= '0;
      sweep_count   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_START && !w_start_last) r_start_cnt <= r_start_cnt + START_W'(1);
      else                                     r_start_cnt <= '0;

      if (r_state == S_SLOTS && !w_slot_last) r_cyc <= r_cyc + CYC_W'(1);
      else                                    r_cyc <= '0;

      if (r_state != S_SLOTS || w_sweep_last) r_idx <= '0;
      else if (w_slot_last)                   r_idx <= r_idx + IDX_W'(1);

      if (r_state == S_SLOTS && w_sweep_last) r_sweep <= w_sweep_nxt;
      else if (r_state == S_DONE && !enable)  r_sweep <= '0;

      start         <= (r_state == S_START);
      channel       <= (r_state == S_SLOTS) && w_chan_win;
      channel_index <= (r_state == S_SLOTS) ? r_idx : '0;
      sweep_count   <= r_sweep;
      busy          <= (r_state == S_START) || (r_state == S_SLOTS);
      done          <= (r_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_messbauer_sweep_generator.sv
// Randomized bench: three generator configurations driven by shared enable/reset,
// each checked every cycle against a sweep-cycle arithmetic reference model.
module tb_messbauer_sweep_generator;

  localparam int NCH = 4;
  localparam int PER = 5;
  localparam int SD  = 2;
  localparam int LEN = SD + NCH * PER;
  localparam int ND  = 3;

  typedef struct packed {
    logic        start;
    logic        channel;
    logic        busy;
    logic        done;
    logic [1:0]  idx;
    logic [15:0] cnt;
  } exp_t;

  logic aclk;
  logic areset;
  logic enable;

  logic [ND-1:0] w_start, w_channel, w_busy, w_done;
  logic [1:0]    w_idx [ND];
  logic [15:0]   w_cnt [ND];

  messbauer_sweep_generator #(
    .CHANNEL_NUMBER(NCH), .CHANNEL_PERIOD(PER), .START_DURATION(SD),
    .CHANNEL_DURATION(1), .CHANNEL_TYPE(2), .SWEEPS_LIMIT(0), .SWEEP_COUNTER_WIDTH(16)
  ) u_t2 (
    .aclk(aclk), .areset(areset), .enable(enable),
    .start(w_start[0]), .channel(w_channel[0]), .channel_index(w_idx[0]),
    .sweep_count(w_cnt[0]), .busy(w_busy[0]), .done(w_done[0])
  );

  messbauer_sweep_generator #(
    .CHANNEL_NUMBER(NCH), .CHANNEL_PERIOD(PER), .START_DURATION(SD),
    .CHANNEL_DURATION(1), .CHANNEL_TYPE(1), .SWEEPS_LIMIT(3), .SWEEP_COUNTER_WIDTH(16)
  ) u_t1 (
    .aclk(aclk), .areset(areset), .enable(enable),
    .start(w_start[1]), .channel(w_channel[1]), .channel_index(w_idx[1]),
    .sweep_count(w_cnt[1]), .busy(w_busy[1]), .done(w_done[1])
  );

  messbauer_sweep_generator #(
    .CHANNEL_NUMBER(NCH), .CHANNEL_PERIOD(PER), .START_DURATION(SD),
    .CHANNEL_DURATION(4), .CHANNEL_TYPE(2), .SWEEPS_LIMIT(0), .SWEEP_COUNTER_WIDTH(16)
  ) u_d4 (
    .aclk(aclk), .areset(areset), .enable(enable),
    .start(w_start[2]), .channel(w_channel[2]), .channel_index(w_idx[2]),
    .sweep_count(w_cnt[2]), .busy(w_busy[2]), .done(w_done[2])
  );

  initial aclk = 1'b0;
  always #20 aclk = ~aclk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string nm  [ND] = '{"t2", "t1", "d4"};
  int    typ [ND] = '{2, 1, 2};
  int    dur [ND] = '{1, 1, 4};
  int    lim [ND] = '{0, 3, 0};

  // Model: mode 0 idle, 1 sweeping at sweep cycle m_s, 2 limit reached
  int          m_mode [ND];
  int          m_s    [ND];
  int unsigned m_cnt  [ND];
  exp_t        e      [ND];

  int starts_t1 = 0;
  bit prev_s1   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t view(input int k);
    exp_t v;
    int   off;
    v = '0;
    v.cnt  = 16'(m_cnt[k]);
    v.done = (m_mode[k] == 2);
    if (m_mode[k] == 1) begin
      v.busy  = 1'b1;
      v.start = (m_s[k] < SD);
      if (m_s[k] >= SD) begin
        off       = (m_s[k] - SD) % PER;
        v.idx     = 2'((m_s[k] - SD) / PER);
        v.channel = (typ[k] == 1) ? (off < dur[k]) : (off >= PER - dur[k]);
      end
    end
    return v;
  endfunction

  task automatic step(input int k, input bit en);
    case (m_mode[k])
      0: if (en) begin m_mode[k] = 1; m_s[k] = 0; end
      1: begin
        if (m_s[k] == LEN - 1) begin
          m_cnt[k] = (m_cnt[k] + 1) % 65536;
          if (lim[k] != 0 && m_cnt[k] == lim[k]) m_mode[k] = 2;
          else if (en)                            m_s[k] = 0;
          else                                    m_mode[k] = 0;
        end else begin
          m_s[k]++;
        end
      end
      default: if (!en) begin m_mode[k] = 0; m_cnt[k] = 0; end
    endcase
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge
  task automatic cycle(input bit rst, input bit en);
    areset = rst;
    enable = en;
    @(posedge aclk);
    for (int k = 0; k < ND; k++) begin
      if (rst) begin
        e[k] = '0; m_mode[k] = 0; m_s[k] = 0; m_cnt[k] = 0;
      end else begin
        e[k] = view(k);
        step(k, en);
      end
    end
    @(negedge aclk);
    for (int k = 0; k < ND; k++) begin
      chk({nm[k], ".start"},   32'(w_start[k]),   32'(e[k].start));
      chk({nm[k], ".channel"}, 32'(w_channel[k]), 32'(e[k].channel));
      chk({nm[k], ".busy"},    32'(w_busy[k]),    32'(e[k].busy));
      chk({nm[k], ".done"},    32'(w_done[k]),    32'(e[k].done));
      chk({nm[k], ".index"},   32'(w_idx[k]),     32'(e[k].idx));
      chk({nm[k], ".count"},   32'(w_cnt[k]),     32'(e[k].cnt));
    end
    if (w_start[1] && !prev_s1) starts_t1++;
    prev_s1 = w_start[1];
  endtask

  initial begin
    int len;
    bit en;
    areset = 1'b1;
    enable = 1'b0;
    repeat (3) cycle(1'b1, 1'b0);

    // Continuous run: limit configuration reaches three sweeps
    starts_t1 = 0;
    repeat (80) cycle(1'b0, 1'b1);
    chk("t1.start_pulses", 32'(starts_t1), 32'd3);

    // Release from DONE, then mid-sweep enable drop and re-arm
    repeat (30) cycle(1'b0, 1'b0);
    repeat (9)  cycle(1'b0, 1'b1);
    repeat (30) cycle(1'b0, 1'b0);
    repeat (3)  cycle(1'b0, 1'b1);

    // Reset in the middle of a sweep while enable stays high
    repeat (14) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);

    // Randomized enable segments with occasional resets
    repeat (120) begin
      len = int'($urandom_range(1, 40));
      en  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) cycle(1'b1, en);
      repeat (len) cycle(1'b0, en);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/messbauer_sweep_generator.md
# messbauer_sweep_generator

Parametrised successor to the Mössbauer test-environment generator. It produces the `start` pulse that opens each velocity sweep, followed by `CHANNEL_NUMBER` channel-advance pulses positioned before or after each channel's measurement window. New relative to the earlier generator:
- run/stop control via `enable`;
- optional sweep-count limit with a `done` flag;
- channel index and sweep counter outputs that feed the spectrum accumulator and testbench checkers.

## Interface

**Parameters**
- `CHANNEL_NUMBER`, default 4096: channel slots per sweep; must be ≥ 2.
- `CHANNEL_PERIOD`, default 100: `aclk` cycles per channel slot; must be ≥ 2.
- `START_DURATION`, default 10: cycles `start` stays high at sweep begin; must be ≥ 1.
- `CHANNEL_DURATION`, default 1: cycles `channel` stays high per slot; must satisfy 1 ≤ `CHANNEL_DURATION` < `CHANNEL_PERIOD`.
- `CHANNEL_TYPE`, default 2: 1 = pulse at the beginning of the slot (channel before measurement); 2 = pulse at the end of the slot (channel after measurement). Any other value is a synthesis error.
- `SWEEPS_LIMIT`, default 0: number of sweeps to run, then stop; 0 = unlimited.
- `SWEEP_COUNTER_WIDTH`, default 16: width of `sweep_count`.

**Ports**
- `aclk` input 1: clock; all logic is on the rising edge.
- `areset` input 1: synchronous, active-high reset.
- `enable` input 1: run request, level-sensitive.
- `start` output 1: sweep start pulse.
- `channel` output 1: channel pulse.
- `channel_index` output clog2(`CHANNEL_NUMBER`): current slot number.
- `sweep_count` output `SWEEP_COUNTER_WIDTH`: completed sweeps.
- `busy` output 1: a sweep is in progress.
- `done` output 1: `SWEEPS_LIMIT` has been reached.

## Operation

- All outputs are registered. While `areset` is high at an edge, every output is 0 after that edge and the FSM is in IDLE.
- **FSM states:** IDLE, START, SLOTS, DONE.
- **IDLE:** `enable`=1 → START.
- **START:** lasts `START_DURATION` cycles, with `start`=1 and `busy`=1. Then → SLOTS with `channel_index`=0.
- **SLOTS:**
  - There are `CHANNEL_NUMBER` slots of `CHANNEL_PERIOD` cycles each. A cycle counter (clog2(`CHANNEL_PERIOD`) bits) runs 0..`CHANNEL_PERIOD`−1.
  - `channel_index` increments when the counter wraps.
  - `CHANNEL_TYPE`=1: `channel`=1 while the counter is in 0..`CHANNEL_DURATION`−1.
  - `CHANNEL_TYPE`=2: `channel`=1 while the counter is in `CHANNEL_PERIOD`−`CHANNEL_DURATION`..`CHANNEL_PERIOD`−1.
- **End of sweep** (last cycle of slot `CHANNEL_NUMBER`−1):
  - `sweep_count` increments and wraps modulo 2^`SWEEP_COUNTER_WIDTH`.
  - If the limit is reached (`SWEEPS_LIMIT`≠0 and the new count equals `SWEEPS_LIMIT`) → DONE.
  - Else if `enable`=1 → START. This is back-to-back: no idle cycle.
  - Else → IDLE.
- **`enable` deassertion mid-sweep** never truncates the sweep. The current sweep completes, then the FSM goes to IDLE.
- **DONE:** `done`=1, `busy`=0, `start`=`channel`=0. On `enable`=0 → IDLE, which clears `done` and `sweep_count`. `areset` also clears both.
- **`channel_index`:** holds 0 in IDLE, START and DONE.
- **Sweep length:** `START_DURATION` + `CHANNEL_NUMBER`·`CHANNEL_PERIOD` cycles. Internal counters must not overflow at the maximum parameters.

## Timing

- `enable` is sampled at edge N in IDLE → `start`=1 and `busy`=1 from edge N+1. This is "sweep cycle 0".
- Sweep cycle s (relative to cycle 0):
  - `start`=1 for 0 ≤ s < `START_DURATION`.
  - Slot k occupies cycles `START_DURATION`+k·`CHANNEL_PERIOD` through `START_DURATION`+(k+1)·`CHANNEL_PERIOD`−1.
- **Back-to-back:** the next sweep's cycle 0 immediately follows the previous sweep's last cycle.
- `sweep_count` and `done` update at the edge that ends the final cycle of a sweep. `busy` falls at that same edge when the next state is IDLE or DONE.
- **Reset mid-sweep:** outputs are 0 on the next edge. The FSM restarts from IDLE even if `enable` is held.

## Test plan

Common setup for all scenarios:
- Clock period 40 ns.
- `CHANNEL_NUMBER`=4, `CHANNEL_PERIOD`=5, `START_DURATION`=2, `CHANNEL_DURATION`=1 (sweep = 22 cycles).

Scenarios:
- **TYPE=2, `enable` held high after reset** → `start` high at sweep cycles 0–1; `channel` high at cycles 6, 11, 16, 21; `channel_index` 0/1/2/3 across cycles 2–6/7–11/12–16/17–21; next `start` at cycle 22; `sweep_count`=1 at cycle 22.
- **TYPE=1, same stimulus** → `channel` high at cycles 2, 7, 12, 17, and nowhere else.
- **`enable` dropped at sweep cycle 8** → sweep completes through cycle 21; `busy`=0 from cycle 22; no `start` afterwards; `sweep_count`=1. Re-asserting `enable` → `start` one cycle later.
- **`SWEEPS_LIMIT`=3, `enable` high** → exactly 3 `start` pulses (cycles 0, 22, 44); `done`=1 and `sweep_count`=3 from cycle 66. Dropping `enable` → `done`=0 and `sweep_count`=0 next cycle.
- **`areset` pulsed at sweep cycle 13** → all outputs 0 next cycle. After release with `enable`=1, a fresh `start` comes one cycle after the first sampled `enable` edge.
- **`CHANNEL_DURATION`=4, TYPE=2** → `channel` high at cycles 3–6, 8–11, 13–16, 18–21; never overlaps `start`.
